aos_sr_txn_ctrl: RTL and testbench

AOS_SR_TXN_CTRL -- requirements
Module: aos_sr_txn_ctrl

---
 rtl/aos_sr_txn_ctrl_pkg.sv | 17 +
 rtl/aos_sr_txn_ctrl_fifo.sv | 41 ++++
 rtl/aos_sr_txn_ctrl.sv | 104 ++++++++++
 tb/tb_aos_sr_txn_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/aos_sr_txn_ctrl_pkg.sv
// aos_sr_txn_ctrl_pkg: soft-register request/response types and the error payload.
package AMITypes;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;
  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;
endpackage

package AOSF1Types;
  localparam logic [63:0] SR_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
endpackage

// File: rtl/aos_sr_txn_ctrl_fifo.sv
// HullFIFO: show-ahead synchronous FIFO holding 2**LOG_DEPTH entries.
module HullFIFO #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic wr_go, rd_go;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {LOG_DEPTH{1'b0}}};
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
  always_comb begin
    wr_go    = wr_en && !full;
    rd_go    = rd_en && !empty;
    wr_ptr_d = wr_go ? wr_ptr_q + (LOG_DEPTH+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_go ? rd_ptr_q + (LOG_DEPTH+1)'(1) : rd_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= wr_data;
  end
endmodule

// File: rtl/aos_sr_txn_ctrl.sv
// aos_sr_txn_ctrl: buffers host soft-register requests, forwards them to apps and
// tracks one outstanding read with timeout, synthesising error responses.
module aos_sr_txn_ctrl
  import AMITypes::*;
  import AOSF1Types::*;
#(
  parameter int SR_NUM_APPS    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_LOG_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SR_NUM_APPS-1:0] app_enable,
  input  SoftRegReq              host_req,
  output SoftRegResp             host_resp,
  output SoftRegReq              tree_req,
  input  SoftRegResp             tree_resp,
  output logic                   busy,
  output logic [15:0]            stat_timeouts,
  output logic [15:0]            stat_drops,
  output logic [15:0]            stat_stray
);
  typedef enum logic {IDLE, WAIT_RESP} state_e;
  localparam int AW = SR_NUM_APPS > 1 ? $clog2(SR_NUM_APPS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  SoftRegResp host_resp_q, host_resp_d;
  SoftRegReq tree_req_q, tree_req_d, head;
  logic [15:0] timeouts_q, timeouts_d, drops_q, drops_d, stray_q, stray_d;
  logic [AW-1:0] head_app;
  logic full, empty, pop, head_en;
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
  HullFIFO #(.WIDTH($bits(SoftRegReq)), .LOG_DEPTH(FIFO_LOG_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(rst_n),
    .wr_en  (host_req.valid),
    .wr_data(host_req),
    .full   (full),
    .rd_en  (pop),
    .rd_data(head),
    .empty  (empty)
  );
  always_comb begin
    head_app    = (SR_NUM_APPS == 1) ? '0 : head.addr[3 +: AW];
    head_en     = app_enable[head_app];
    pop         = state_q == IDLE && !empty;
    state_d     = state_q;
    timer_d     = timer_q;
    host_resp_d = '0;
    tree_req_d  = '0;
    timeouts_d  = timeouts_q;
    stray_d     = sat_add(stray_q, {1'b0, state_q == IDLE && tree_resp.valid});
    drops_d     = sat_add(drops_q, {1'b0, host_req.valid && full} + {1'b0, pop && head.is_write && !head_en});
    if (state_q == WAIT_RESP) begin
      timer_d = timer_q + TW'(1);
      if (tree_resp.valid) begin
        host_resp_d = tree_resp;
        state_d     = IDLE;
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        host_resp_d = '{valid: 1'b1, data: SR_ERR_DATA};
        timeouts_d  = sat_add(timeouts_q, 2'd1);
        state_d     = IDLE;
      end
    end else if (pop) begin
      tree_req_d = head_en ? head : '0;
      if (!head.is_write && head_en) begin
        state_d = WAIT_RESP;
        timer_d = '0;
      end else if (!head.is_write) begin
        host_resp_d = '{valid: 1'b1, data: SR_ERR_DATA};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      host_resp_q <= '0;
      tree_req_q  <= '0;
      timeouts_q  <= '0;
      drops_q     <= '0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      host_resp_q <= host_resp_d;
      tree_req_q  <= tree_req_d;
      timeouts_q  <= timeouts_d;
      drops_q     <= drops_d;
      stray_q     <= stray_d;
    end
  end
  assign host_resp     = host_resp_q;
  assign tree_req      = tree_req_q;
  assign busy          = state_q == WAIT_RESP;
  assign stat_timeouts = timeouts_q;
  assign stat_drops    = drops_q;
  assign stat_stray    = stray_q;
endmodule

// File: tb/tb_aos_sr_txn_ctrl.sv
// tb_aos_sr_txn_ctrl: directed scenarios plus random traffic checked every cycle
// against a queue-based transaction model.
module tb_aos_sr_txn_ctrl;
  import AMITypes::*;
  import AOSF1Types::*;
  localparam int NA = 4, TO = 8, LD = 2, DEPTH = 1 << LD;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NA-1:0] app_enable;
  SoftRegReq host_req, tree_req;
  SoftRegResp host_resp, tree_resp;
  logic busy;
  logic [15:0] stat_timeouts, stat_drops, stat_stray;
  int checks = 0, failures = 0;
  SoftRegReq q[$];
  bit waiting;
  int elapsed, m_to, m_dr, m_st, n, nb;
  SoftRegResp m_host;
  SoftRegReq m_tree, wr;

  always #5 clk = ~clk;

  aos_sr_txn_ctrl #(.SR_NUM_APPS(NA), .TIMEOUT_CYCLES(TO), .FIFO_LOG_DEPTH(LD)) dut (
    .clk(clk), .rst_n(rst_n), .app_enable(app_enable), .host_req(host_req),
    .host_resp(host_resp), .tree_req(tree_req), .tree_resp(tree_resp), .busy(busy),
    .stat_timeouts(stat_timeouts), .stat_drops(stat_drops), .stat_stray(stat_stray)
  );

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(int x);
    return x > 65535 ? 65535 : x;
  endfunction

  function automatic int app_of(SoftRegReq r);
    return int'(r.addr[31:3]) % NA;
  endfunction

  // one clock of transaction-level behaviour, using the inputs present at the edge
  task automatic model_update();
    bit was_full;
    SoftRegReq r;
    was_full = q.size() == DEPTH;
    if (!rst_n) begin
      q.delete();
      waiting = 0; elapsed = 0; m_host = '0; m_tree = '0; m_to = 0; m_dr = 0; m_st = 0;
      return;
    end
    m_host = '0;
    m_tree = '0;
    if (waiting) begin
      if (tree_resp.valid) begin
        m_host = tree_resp; waiting = 0;
      end else if (elapsed == TO - 1) begin
        m_host = '{valid: 1'b1, data: SR_ERR_DATA}; m_to = sat(m_to + 1); waiting = 0;
      end else elapsed++;
    end else begin
      if (tree_resp.valid) m_st = sat(m_st + 1);
      if (q.size() > 0) begin
        r = q.pop_front();
        if (!app_enable[app_of(r)]) begin
          if (r.is_write) m_dr = sat(m_dr + 1);
          else m_host = '{valid: 1'b1, data: SR_ERR_DATA};
        end else begin
          m_tree = r;
          if (!r.is_write) begin waiting = 1; elapsed = 0; end
        end
      end
    end
    if (host_req.valid) begin
      if (was_full) m_dr = sat(m_dr + 1);
      else q.push_back(host_req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("host_resp", 128'(host_resp), 128'(m_host));
    check("tree_req", 128'(tree_req), 128'(m_tree));
    check("busy", 128'(busy), 128'(waiting));
    check("timeouts", 128'(stat_timeouts), 128'(m_to));
    check("drops", 128'(stat_drops), 128'(m_dr));
    check("stray", 128'(stat_stray), 128'(m_st));
  endtask

  task automatic idle();
    host_req = '0;
    tree_resp = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(bit is_wr, logic [31:0] addr, logic [63:0] data);
    host_req = '{valid: 1'b1, is_write: is_wr, addr: addr, data: data};
  endtask

  initial begin
    idle();
    app_enable = '1;
    do_reset();
    check("rst_resp", 128'(host_resp), 128'(0));
    check("rst_tree", 128'(tree_req), 128'(0));
    // write to enabled app 1
    wr = '{valid: 1'b1, is_write: 1'b1, addr: 32'h08, data: 64'h55};
    host_req = wr; step(); idle(); step();
    check("wr_tree", 128'(tree_req), 128'(wr));
    check("wr_noresp", 128'(host_resp.valid), 128'(0));
    // read with response 5 cycles after issue
    do_reset();
    send(0, 32'h00, 64'h0); step(); idle(); step();
    nb = busy;
    repeat (4) begin step(); nb += busy; end
    tree_resp = '{valid: 1'b1, data: 64'h1234}; step(); idle();
    nb += busy;
    check("rd_data", 128'(host_resp), 128'({1'b1, 64'h1234}));
    check("rd_busy_cycles", 128'(nb), 128'(5));
    // read that times out, then a late response
    do_reset();
    send(0, 32'h00, 64'h0); step(); idle(); step();
    n = 0;
    do begin step(); n++; end while (!host_resp.valid && n < 20);
    check("to_latency", 128'(n), 128'(TO));
    check("to_data", 128'(host_resp.data), 128'(SR_ERR_DATA));
    check("to_count", 128'(stat_timeouts), 128'(1));
    tree_resp = '{valid: 1'b1, data: 64'h77}; step(); idle();
    check("late_stray", 128'(stat_stray), 128'(1));
    check("late_noresp", 128'(host_resp.valid), 128'(0));
    // disabled app 1
    do_reset();
    app_enable = 4'b1101;
    send(0, 32'h08, 64'h0); step(); idle(); step();
    check("dis_rd_resp", 128'(host_resp), 128'({1'b1, SR_ERR_DATA}));
    check("dis_rd_notree", 128'(tree_req.valid), 128'(0));
    send(1, 32'h08, 64'h99); step(); idle(); step();
    check("dis_wr_drop", 128'(stat_drops), 128'(1));
    check("dis_wr_notree", 128'(tree_req.valid), 128'(0));
    // overflow while a read is outstanding
    do_reset();
    app_enable = '1;
    send(0, 32'h00, 64'h0); step(); idle(); step();
    for (int i = 0; i < 6; i++) begin send(1, 32'h00, 64'(i)); step(); end
    idle();
    check("ovf_drops", 128'(stat_drops), 128'(2));
    tree_resp = '{valid: 1'b1, data: 64'hAB}; step(); idle();
    n = 0;
    repeat (8) begin step(); n += tree_req.valid; end
    check("ovf_buffered", 128'(n), 128'(DEPTH));
    // reset in the middle of a wait
    do_reset();
    send(0, 32'h00, 64'h0); step(); idle(); step(); step();
    check("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_stats", 128'({stat_timeouts, stat_drops, stat_stray}), 128'(0));
    tree_resp = '{valid: 1'b1, data: 64'h5}; step(); idle();
    check("mid_stray", 128'(stat_stray), 128'(1));
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 49) == 0) app_enable = NA'($urandom);
      if ($urandom_range(0, 2) == 0)
        send(1'($urandom), $urandom, {$urandom, $urandom});
      else host_req = '0;
      tree_resp = ($urandom_range(0, 9) == 0) ? '{valid: 1'b1, data: {$urandom, $urandom}} : '0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
